// File: rtl/neuron_ctrl.sv
// Command sequencer for a single neuron: holds weights, inputs, config and threshold,
// and runs a three-phase step (accept, settle, commit) that captures the neuron's result.
module neuron_ctrl #(
   parameter int n_stage = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   input  logic [2:0]           cmd,
   input  logic [7:0]           data_in,
   output logic                 cmd_ready,
   output logic [2**n_stage-1:0] w,
   output logic [2**n_stage-1:0] x,
   output logic [2:0]           shift,
   output logic [3:0]           BN_factor,
   output logic [n_stage+1:0]   minus_teta,
   output logic [n_stage+1:0]   BN_addend,
   output logic [n_stage+1:0]   previus_u,
   output logic                 was_spike,
   input  logic [n_stage+1:0]   u_out,
   input  logic                 is_spike,
   output logic                 spike_out,
   output logic                 step_done,
   output logic [7:0]           spike_count
);
   localparam int N = 2**n_stage;
   localparam int U = n_stage + 2;

   localparam logic [2:0] OP_LOAD_W     = 3'd0;
   localparam logic [2:0] OP_LOAD_X     = 3'd1;
   localparam logic [2:0] OP_LOAD_CFG   = 3'd2;
   localparam logic [2:0] OP_LOAD_TETA  = 3'd3;
   localparam logic [2:0] OP_LOAD_BNADD = 3'd4;
   localparam logic [2:0] OP_STEP       = 3'd5;
   localparam logic [2:0] OP_CLR_U      = 3'd6;
   localparam logic [2:0] OP_NOP        = 3'd7;

   typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

   state_t       r_state;
   logic [N-1:0] r_w;
   logic [N-1:0] r_x;
   logic [2:0]   r_shift;
   logic [3:0]   r_bn_factor;
   logic [U-1:0] r_minus_teta;
   logic [U-1:0] r_bn_addend;
   logic [U-1:0] r_previus_u;
   logic         r_was_spike;
   logic         r_spike_out;
   logic         r_step_done;
   logic [7:0]   r_spike_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_w           <= '0;
         r_x           <= '0;
         r_shift       <= '0;
         r_bn_factor   <= '0;
         r_minus_teta  <= '0;
         r_bn_addend   <= '0;
         r_previus_u   <= '0;
         r_was_spike   <= 1'b0;
         r_spike_out   <= 1'b0;
         r_step_done   <= 1'b0;
         r_spike_count <= '0;
      end else begin
         r_step_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  case (cmd)
                     OP_LOAD_W:     r_w          <= data_in[N-1:0];
                     OP_LOAD_X:     r_x          <= data_in[N-1:0];
                     OP_LOAD_CFG: begin
                        r_shift     <= data_in[2:0];
                        r_bn_factor <= data_in[7:4];
                     end
                     OP_LOAD_TETA:  r_minus_teta <= data_in[U-1:0];
                     OP_LOAD_BNADD: r_bn_addend  <= data_in[U-1:0];
                     OP_STEP:       r_state      <= EVAL;
                     OP_CLR_U: begin
                        r_previus_u   <= '0;
                        r_was_spike   <= 1'b0;
                        r_spike_out   <= 1'b0;
                        r_spike_count <= '0;
                     end
                     OP_NOP: ;
                     default: ;
                  endcase
               end
            end
            // Settle cycle: the neuron sees stable operands before its result is captured.
            EVAL: r_state <= COMMIT;
            COMMIT: begin
               r_state     <= IDLE;
               r_previus_u <= u_out;
               r_was_spike <= is_spike;
               r_spike_out <= is_spike;
               r_step_done <= 1'b1;
               if (is_spike && (r_spike_count != 8'hFF))
                  r_spike_count <= r_spike_count + 8'd1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = (r_state == IDLE);
   assign w           = r_w;
   assign x           = r_x;
   assign shift       = r_shift;
   assign BN_factor   = r_bn_factor;
   assign minus_teta  = r_minus_teta;
   assign BN_addend   = r_bn_addend;
   assign previus_u   = r_previus_u;
   assign was_spike   = r_was_spike;
   assign spike_out   = r_spike_out;
   assign step_done   = r_step_done;
   assign spike_count = r_spike_count;

endmodule

// File: tb/tb_neuron_ctrl.sv
// Self-checking bench for neuron_ctrl: load table, step timing, stall, reset abort,
// saturation, and randomized commands against a register-level reference model.
module tb_neuron_ctrl;
   localparam int N = 4;
   localparam int U = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic [2:0]   cmd = 3'd7;
   logic [7:0]   data_in = 8'd0;
   logic         cmd_ready;
   logic [N-1:0] w, x;
   logic [2:0]   shift;
   logic [3:0]   BN_factor;
   logic [U-1:0] minus_teta, BN_addend, previus_u;
   logic         was_spike;
   logic [U-1:0] u_out = '0;
   logic         is_spike = 1'b0;
   logic         spike_out, step_done;
   logic [7:0]   spike_count;

   neuron_ctrl #(.n_stage(2)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .data_in(data_in),
      .cmd_ready(cmd_ready), .w(w), .x(x), .shift(shift), .BN_factor(BN_factor),
      .minus_teta(minus_teta), .BN_addend(BN_addend), .previus_u(previus_u),
      .was_spike(was_spike), .u_out(u_out), .is_spike(is_spike), .spike_out(spike_out),
      .step_done(step_done), .spike_count(spike_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [N-1:0] m_w, m_x;
   logic [2:0]   m_shift;
   logic [3:0]   m_bnf;
   logic [U-1:0] m_teta, m_bnadd, m_pu;
   logic         m_spk;
   int           m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_w = '0; m_x = '0; m_shift = '0; m_bnf = '0; m_teta = '0; m_bnadd = '0;
      m_pu = '0; m_spk = 1'b0; m_cnt = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".w"}, 32'(w), 32'(m_w));
      chk({tag, ".x"}, 32'(x), 32'(m_x));
      chk({tag, ".shift"}, 32'(shift), 32'(m_shift));
      chk({tag, ".bnf"}, 32'(BN_factor), 32'(m_bnf));
      chk({tag, ".teta"}, 32'(minus_teta), 32'(m_teta));
      chk({tag, ".bnadd"}, 32'(BN_addend), 32'(m_bnadd));
      chk({tag, ".prev_u"}, 32'(previus_u), 32'(m_pu));
      chk({tag, ".was_spike"}, 32'(was_spike), 32'(m_spk));
      chk({tag, ".spike_out"}, 32'(spike_out), 32'(m_spk));
      chk({tag, ".count"}, 32'(spike_count), 32'(m_cnt));
   endtask

   // Present a command and hold it until accepted; returns right after the accepting edge (+1).
   task automatic issue(input logic [2:0] c, input logic [7:0] d);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1; cmd = c; data_in = d;
      n = 0;
      while (!cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) begin
         chk("accept_timeout", 32'(cmd_ready), 32'd1);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd = 3'd7; data_in = $urandom;
      $display("cmd %0d data %02h accepted at %0t", c, d, $time);
   endtask

   // Full step with timing checks; neuron stub outputs held at u/s.
   task automatic do_step(input logic [U-1:0] u, input logic s, input bit timing);
      u_out = u; is_spike = s;
      issue(3'd5, 8'h00);
      if (timing) begin
         chk("step.ready_c1", 32'(cmd_ready), 32'd0);
         chk("step.done_c1", 32'(step_done), 32'd0);
      end
      @(posedge clk); #1;
      if (timing) begin
         chk("step.ready_c2", 32'(cmd_ready), 32'd0);
         chk("step.done_c2", 32'(step_done), 32'd0);
      end
      @(posedge clk); #1;
      m_pu = u; m_spk = s;
      if (s && m_cnt < 255) m_cnt++;
      if (timing) begin
         chk("step.done_c3", 32'(step_done), 32'd1);
         chk("step.ready_c3", 32'(cmd_ready), 32'd1);
      end
   endtask

   // Apply one command to the model using the specification's field rules.
   task automatic model_cmd(input logic [2:0] c, input logic [7:0] d);
      case (c)
         3'd0: m_w = d[N-1:0];
         3'd1: m_x = d[N-1:0];
         3'd2: begin m_shift = d[2:0]; m_bnf = d[7:4]; end
         3'd3: m_teta = d[U-1:0];
         3'd4: m_bnadd = d[U-1:0];
         3'd6: begin m_pu = '0; m_spk = 1'b0; m_cnt = 0; end
         default: ;
      endcase
   endtask

   typedef struct {
      logic [2:0] c;
      logic [7:0] d;
      logic [3:0] ew, ex;
      logic [2:0] esh;
      logic [3:0] ebf, et, eba;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [2:0] rc;
      logic [7:0] rd;
      vecs[0] = '{3'd0, 8'h0F, 4'hF, 4'h0, 3'd0, 4'h0, 4'h0, 4'h0};
      vecs[1] = '{3'd1, 8'h05, 4'hF, 4'h5, 3'd0, 4'h0, 4'h0, 4'h0};
      vecs[2] = '{3'd2, 8'h32, 4'hF, 4'h5, 3'd2, 4'h3, 4'h0, 4'h0};
      vecs[3] = '{3'd3, 8'h0C, 4'hF, 4'h5, 3'd2, 4'h3, 4'hC, 4'h0};
      vecs[4] = '{3'd4, 8'hF9, 4'hF, 4'h5, 3'd2, 4'h3, 4'hC, 4'h9};
      vecs[5] = '{3'd7, 8'hFF, 4'hF, 4'h5, 3'd2, 4'h3, 4'hC, 4'h9};
      vecs[6] = '{3'd2, 8'hA7, 4'hF, 4'h5, 3'd7, 4'hA, 4'hC, 4'h9};

      model_reset();
      #1;
      check_all("reset");
      chk("reset.done", 32'(step_done), 32'd0);
      #20;
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("reset.ready", 32'(cmd_ready), 32'd1);

      // load table
      for (int i = 0; i < 7; i++) begin
         issue(vecs[i].c, vecs[i].d);
         chk("tbl.w", 32'(w), 32'(vecs[i].ew));
         chk("tbl.x", 32'(x), 32'(vecs[i].ex));
         chk("tbl.shift", 32'(shift), 32'(vecs[i].esh));
         chk("tbl.bnf", 32'(BN_factor), 32'(vecs[i].ebf));
         chk("tbl.teta", 32'(minus_teta), 32'(vecs[i].et));
         chk("tbl.bnadd", 32'(BN_addend), 32'(vecs[i].eba));
         chk("tbl.ready", 32'(cmd_ready), 32'd1);
         model_cmd(vecs[i].c, vecs[i].d);
      end

      // basic step with spiking neuron
      do_step(4'h7, 1'b1, 1'b1);
      check_all("step1");
      @(posedge clk); #1;
      chk("step1.done_once", 32'(step_done), 32'd0);
      $display("step u=7 spike=1 count=%0d", spike_count);

      // load presented during EVAL stalls until the step_done cycle
      u_out = 4'h3; is_spike = 1'b0;
      issue(3'd5, 8'h00);
      @(negedge clk);
      cmd_valid = 1'b1; cmd = 3'd0; data_in = 8'h0A;
      @(posedge clk); #1;
      chk("stall.w_commit", 32'(w), 32'(m_w));
      chk("stall.ready_commit", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      chk("stall.w_done", 32'(w), 32'(m_w));
      chk("stall.done", 32'(step_done), 32'd1);
      m_pu = 4'h3; m_spk = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd = 3'd7;
      m_w = 4'hA;
      check_all("stall");
      $display("stalled LOAD_W applied w=%0h", w);

      // back-to-back steps at minimum period
      do_step(4'h9, 1'b1, 1'b1);
      do_step(4'h2, 1'b0, 1'b1);
      check_all("b2b");

      // CLR_U keeps weights/config
      issue(3'd6, 8'h55);
      model_cmd(3'd6, 8'h55);
      check_all("clr");

      // reset pulse during EVAL aborts the step
      u_out = 4'h5; is_spike = 1'b1;
      issue(3'd5, 8'h00);
      @(negedge clk); rst_n = 1'b0;
      #2 rst_n = 1'b1;
      #1;
      model_reset();
      check_all("abort");
      chk("abort.ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      chk("abort.done", 32'(step_done), 32'd0);
      @(posedge clk); #1;
      chk("abort.done2", 32'(step_done), 32'd0);
      check_all("abort2");
      $display("reset abort checked");

      // randomized commands against the model
      for (int i = 0; i < 60; i++) begin
         rc = 3'($urandom_range(0, 7));
         rd = 8'($urandom);
         if (rc == 3'd5) begin
            do_step(4'($urandom), 1'($urandom), 1'b1);
         end else begin
            issue(rc, rd);
            model_cmd(rc, rd);
         end
         check_all("rand");
      end

      // saturation
      issue(3'd6, 8'h00);
      model_cmd(3'd6, 8'h00);
      for (int i = 0; i < 300; i++) begin
         do_step(4'($urandom), 1'b1, 1'b0);
         if (i == 254 || i == 255 || i == 299) chk("sat.count", 32'(spike_count), 32'(m_cnt));
      end
      chk("sat.final", 32'(spike_count), 32'd255);
      check_all("sat");
      $display("after 300 spiking steps count=%0d", spike_count);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/neuron_ctrl.md
NEURON_CTRL -- requirements
Module: neuron_ctrl

Interface
REQ-001 SHALL have parameter n_stage, default 2, meaning neuron size; legal 1..3; N = 2**n_stage (w/x width), U = n_stage+2 (potential width).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd  input  3  opcode: 0 LOAD_W, 1 LOAD_X, 2 LOAD_CFG, 3 LOAD_TETA, 4 LOAD_BNADD, 5 STEP, 6 CLR_U, 7 NOP.
REQ-006 SHALL have port data_in  input  8  command payload.
REQ-007 SHALL have port cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 SHALL have ports w, x  output  N each; shift  output  3; BN_factor  output  4; minus_teta, BN_addend, previus_u  output  U each; was_spike  output  1; all driven to the neuron.
REQ-009 SHALL have ports u_out  input  U and is_spike  input  1, both from the neuron.
REQ-010 SHALL have ports spike_out  output  1  registered spike of last step; step_done  output  1  one-cycle pulse; spike_count  output  8  saturating spike total.

Function
REQ-011 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; otherwise SHALL ignore cmd and data_in.
REQ-012 LOAD_W/LOAD_X SHALL write data_in[N-1:0] to w/x; LOAD_TETA/LOAD_BNADD SHALL write data_in[U-1:0] to minus_teta/BN_addend; LOAD_CFG SHALL write shift=data_in[2:0], BN_factor=data_in[7:4]; unused data bits ignored.
REQ-013 All load commands SHALL take effect the cycle after acceptance and leave the FSM in IDLE; cmd_ready stays high.
REQ-014 FSM states: IDLE, EVAL, COMMIT; cmd_ready SHALL be high only in IDLE.
REQ-015 STEP accepted in IDLE SHALL move to EVAL; EVAL SHALL move to COMMIT unconditionally next cycle (neuron settle cycle); COMMIT SHALL move to IDLE next cycle.
REQ-016 At the COMMIT edge: previus_u <= u_out, was_spike <= is_spike, spike_out <= is_spike, spike_count += is_spike saturating at 255.
REQ-017 step_done SHALL be high exactly the cycle after the COMMIT edge (first cycle back in IDLE); STEP latency = 3 cycles from acceptance to step_done.
REQ-018 w, x, config and threshold registers SHALL hold constant during EVAL/COMMIT; commands presented then SHALL stall (not be lost by the source, not latched here).
REQ-019 CLR_U SHALL set previus_u=0, was_spike=0, spike_out=0, spike_count=0; weights/config unchanged.
REQ-020 NOP SHALL be accepted with no state change.
REQ-021 Back-to-back STEP: next STEP accepted no earlier than the step_done cycle; minimum period 3 cycles.
REQ-022 u_out SHALL be treated as an opaque U-bit value; no sign extension or clipping here.

Reset
REQ-023 rst_n low SHALL asynchronously force FSM=IDLE and all outputs/registers to 0 (w, x, shift, BN_factor, minus_teta, BN_addend, previus_u, was_spike, spike_out, step_done, spike_count); cmd_ready SHALL read 1 while reset is deasserted and FSM is IDLE.
REQ-024 Reset asserted during EVAL/COMMIT SHALL abort the step with no commit; deassertion SHALL be synchronous-safe (first accepted command on the first edge after release).

Verification
REQ-025 Load sequence LOAD_W 0x0F, LOAD_X 0x05, LOAD_CFG 0x32, LOAD_TETA 0x0C -> w=4'hF, x=4'h5, shift=2, BN_factor=3, minus_teta=4'hC one cycle after each accept.
REQ-026 STEP with stubbed neuron u_out=4'h7, is_spike=1 -> cmd_ready low 2 cycles, step_done pulse at cycle 3, previus_u=7, was_spike=1, spike_out=1, spike_count=1.
REQ-027 300 STEPs with is_spike=1 -> spike_count saturates at 255, no wrap.
REQ-028 LOAD_W issued during EVAL with cmd_valid held -> not accepted until step_done cycle, w updates one cycle later, w stable during step.
REQ-029 rst_n pulsed low in COMMIT-pending EVAL cycle -> previus_u stays 0, no step_done, all outputs 0, cmd_ready=1 after release.
REQ-030 CLR_U after spikes -> previus_u=0, was_spike=0, spike_count=0, w/x/config retained.
